// File: rtl/arbiter.sv
// Round-robin bus arbiter: one registered, one-hot grant per clock to a requesting manager.
// Priority starts just after the most recently granted manager and wraps around.
module arbiter #(
  parameter int MANAGERS = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [MANAGERS-1:0] requestV,
  output logic [MANAGERS-1:0] grantedV
);

  localparam int LW = $clog2(MANAGERS);
  localparam logic [LW-1:0] LAST_INIT = LW'(MANAGERS - 1);
  localparam logic [MANAGERS-1:0] ONE = {{(MANAGERS-1){1'b0}}, 1'b1};

  logic [LW-1:0] last;
  logic [LW-1:0] winner;
  logic          found;

  // Scan the priority order last+1, last+2, ... (mod MANAGERS) and keep the first hit.
  always_comb begin
    found  = 1'b0;
    winner = last;
    for (int i = 1; i <= MANAGERS; i++) begin
      if (!found && requestV[(int'(last) + i) % MANAGERS]) begin
        found  = 1'b1;
        winner = LW'((int'(last) + i) % MANAGERS);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grantedV <= '0;
      last     <= LAST_INIT;
    end else if (found) begin
      grantedV <= ONE << winner;
      last     <= winner;
    end else begin
      grantedV <= '0;
    end
  end

endmodule

// File: tb/tb_arbiter.sv
// Self-checking bench for the round-robin arbiter: directed scenarios plus random traffic,
// a priority-order reference model feeding a scoreboard queue, and a separate monitor.
module tb_arbiter;

  localparam int M = 4;

  logic         clk;
  logic         reset;
  logic [M-1:0] requestV;
  logic [M-1:0] grantedV;

  int errors = 0;
  int checks = 0;

  logic [M-1:0] exp_q[$];
  int           mlast;

  arbiter #(.MANAGERS(M)) dut (
    .clk      (clk),
    .reset    (reset),
    .requestV (requestV),
    .grantedV (grantedV)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: build the rotated priority list, grant the first requester in it.
  function automatic logic [M-1:0] model_pick(input logic [M-1:0] req, input int lst,
                                              output int new_last);
    int order[$];
    logic [M-1:0] g;
    g = '0;
    new_last = lst;
    for (int i = 1; i <= M; i++) order.push_back((lst + i) % M);
    foreach (order[j]) begin
      if (req[order[j]]) begin
        g[order[j]] = 1'b1;
        new_last = order[j];
        break;
      end
    end
    return g;
  endfunction

  always @(posedge reset) mlast = M - 1;

  always @(posedge clk) begin
    int nl;
    if (reset) begin
      mlast = M - 1;
      exp_q.push_back('0);
    end else begin
      exp_q.push_back(model_pick(requestV, mlast, nl));
      mlast = nl;
    end
  end

  // Monitor: grant is registered, so compare just after every rising edge.
  always @(posedge clk) begin
    logic [M-1:0] e;
    #1;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty at %0t: got %b, no expected entry", $time, grantedV);
    end else begin
      e = exp_q.pop_front();
      if (grantedV !== e) begin
        errors++;
        $display("FAIL grant at %0t: got %b, expected %b (req %b)", $time, grantedV, e, requestV);
      end
    end
    checks++;
    if (!$onehot0(grantedV)) begin
      errors++;
      $display("FAIL onehot0 at %0t: got %b", $time, grantedV);
    end
  end

  task automatic drive(input logic [M-1:0] v, input int n);
    @(negedge clk);
    requestV = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    requestV = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    bit seen;
    reset = 1'b1;
    requestV = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Idle after reset
    drive(4'b0000, 3);
    // Full contention from reset
    do_reset();
    requestV = 4'b1111;
    repeat (6) @(negedge clk);
    // Sparse requests
    drive(4'b1010, 3);
    drive(4'b0110, 3);
    // Single requester then wrap
    drive(4'b0001, 3);
    drive(4'b0011, 4);
    drive(4'b1011, 3);
    // Truncated decimal literal: only the low nibble 0111 reaches the bus
    do_reset();
    requestV = 4'(1111);
    repeat (8) @(negedge clk);
    checks++;
    if (requestV !== 4'b0111) begin
      errors++;
      $display("FAIL truncation: got req %b, expected 0111", requestV);
    end
    // Grant release to idle
    drive(4'b0000, 2);

    // Asynchronous reset mid-stream, applied while manager 2 holds the grant
    requestV = 4'b1111;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      if (grantedV == 4'b0100) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL wait_grant_0100: got %b, expected 0100 within 20 cycles", grantedV);
    end
    #1 reset = 1'b1;
    #1;
    checks++;
    if (grantedV !== 4'b0000) begin
      errors++;
      $display("FAIL async_reset: got %b, expected 0000 before any edge", grantedV);
    end
    #1 reset = 1'b0;
    @(posedge clk);
    #2;
    checks++;
    if (grantedV !== 4'b0001) begin
      errors++;
      $display("FAIL post_reset_grant: got %b, expected 0001", grantedV);
    end

    // Random traffic, with occasional long holds to exercise rotation
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if ($urandom_range(0, 3) != 0) requestV = M'($urandom_range(0, (1 << M) - 1));
    end

    @(negedge clk);
    requestV = '0;
    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded 100000 time units");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/arbiter.md
Name: arbiter

Overview:
- Parameterised round-robin arbiter for the AHB multi-manager interconnect.
- Samples one request bit per manager each clock and issues a registered, one-hot grant to exactly one requesting manager.
- Priority rotates so that no continuously requesting manager is starved.
- Sits between the manager-side request lines and the bus multiplexer select logic.

Parameters:
- MANAGERS, default 4, number of managers; width of request and grant vectors; legal range 2..32.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- requestV  input  MANAGERS  request vector; bit i high means manager i requests the bus.
- grantedV  output  MANAGERS  registered grant vector; one-hot or all-zero; bit i high means manager i owns the bus.

Behaviour:
- Interface: one clock (clk). Reset is asynchronous and active-high (reset).
- Registered state:
  - grantedV register (MANAGERS bits).
  - Priority pointer `last`, the index of the most recently granted manager, ceil(log2(MANAGERS)) bits.
- Reset (asserted at any time, including mid-operation):
  - grantedV = 0 immediately, without waiting for clk.
  - last = MANAGERS-1, so manager 0 has top priority at the first arbitration.
  - Both hold while reset is high.
- Arbitration on each rising clk edge with reset low:
  - Search requestV starting at index (last+1) mod MANAGERS, ascending with wrap-around.
  - The first index k with requestV[k]=1 wins: grantedV <= one-hot(k), last <= k.
  - If requestV == 0: grantedV <= 0, last unchanged.
- Latency:
  - A grant appears one clock after the request is sampled. No combinational path from requestV to grantedV.
  - Changes to requestV between edges have no effect until the next edge.
- Rotation:
  - With all bits requesting continuously, grants cycle 0,1,2,...,MANAGERS-1,0,...; one grant per clock.
  - A sole requester is re-granted every cycle; wrap-around returns to it.
- Grant release:
  - If the currently granted manager drops its request, it loses the grant at the next edge.
  - Another requester is granted then, or zero if none are requesting.
- Non-requesting managers never receive a grant.
- Invariant, checked by the verifier: $onehot0(grantedV) at all times. When grantedV[i]=1, requestV[i] was 1 at the preceding edge.
- X on requestV bits must not corrupt `last` when requestV is all known at the edge.
  - The verifier drives only known values.
  - The design need not resolve X inputs.

Test Plan:
- Reset then idle: assert reset, release; requestV=0 for 3 clocks -> grantedV=0000 throughout.
- Full contention: requestV=4'b1111 for 6 clocks after reset -> grantedV sequence 0001,0010,0100,1000,0001,0010.
- Sparse requests: from last=0, requestV=4'b1010 -> 0010, 1000, 0010; then requestV=4'b0110 -> 0100, 0010, 0100.
- Wrap and single requester: requestV=4'b0001 for 3 clocks -> 0001 each cycle; then requestV=4'b0011 -> 0010, 0001 alternating; then 4'b1011 -> continues rotation 0010,1000,0001.
- Truncated stimulus: drive requestV=1111 decimal (low nibble 4'b0111) after reset -> 0001,0010,0100,0001; no 1000 ever granted.
- Async reset mid-stream: with requestV=4'b1111 and grant 0100, pulse reset between edges -> grantedV=0 immediately; next edge after release -> 0001.
